// File: rtl/serial_ctrl_pkg.sv
// Shared definitions for the async-serial transmit controller.
// Optional feature macro: SERIAL_TX_PARITY_EN (inserts an even-parity bit before stop).
package serial_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_tx_ctrl_if.sv
// Producer-side handshake and serial line status bundle for serial_tx_ctrl.
interface serial_tx_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             tx_out;
  logic             busy;
  logic             done;

  // Producer drives the word, controller drives the line and status.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  tx_out,
    input  busy,
    input  done
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output tx_out,
    output busy,
    output done
  );
endinterface

// File: rtl/shift_reg_load.sv
// Parallel-load right-shift register; load wins over shift, zeros enter at the MSB.
module shift_reg_load #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  // Register the word on load, otherwise move it one place towards bit 0 on shift.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= d;
    end else if (shift) begin
      q_q <= {1'b0, q_q[WIDTH-1:1]};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/serial_tx_ctrl.sv
// Async-serial transmitter sequencer: start bit, WIDTH data bits LSB-first,
// optional even parity (SERIAL_TX_PARITY_EN), stop bit; each bit lasts DIV clocks.
module serial_tx_ctrl
  import serial_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  serial_tx_ctrl_if.slave  bus
);

  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CntW = $clog2(WIDTH);

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_cnt_q, div_cnt_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  sreg_q;
  logic              load, shift;
  logic              accept;
  logic              last_div;
  logic              last_bit;

`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q;
`endif

  assign accept   = bus.in_valid && (state_q == ST_IDLE);
  // With DIV=1 every cycle is a bit boundary and the divider stays at zero.
  assign last_div = (DIV == 1) ? 1'b1 : (div_cnt_q == DivW'(DIV - 1));
  assign last_bit = (bit_cnt_q == CntW'(WIDTH - 1));

  shift_reg_load #(
    .WIDTH (WIDTH)
  ) u_sreg (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (load),
    .shift   (shift),
    .d       (bus.in_data),
    .q       (sreg_q)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: advance only on bit boundaries once a frame is running.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_START;
      ST_START: if (last_div) state_d = ST_DATA;
      ST_DATA: begin
        if (last_div && last_bit) begin
`ifdef SERIAL_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: if (last_div) state_d = ST_STOP;
`endif
      ST_STOP:  if (last_div) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: shift-register control and the next registered line level,
  // chosen from the bit that becomes current after this edge.
  always_comb begin
    load   = 1'b0;
    shift  = 1'b0;
    tx_d   = tx_q;
    done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tx_d = LINE_IDLE;
        if (accept) begin
          load = 1'b1;
          tx_d = START_LEVEL;
        end
      end
      ST_START: if (last_div) tx_d = sreg_q[0];
      ST_DATA: begin
        if (last_div) begin
          shift = 1'b1;
          if (!last_bit) begin
            tx_d = sreg_q[1];
          end else begin
`ifdef SERIAL_TX_PARITY_EN
            tx_d = parity_q;
`else
            tx_d = LINE_IDLE;
`endif
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: if (last_div) tx_d = LINE_IDLE;
`endif
      ST_STOP: begin
        if (last_div) begin
          tx_d   = LINE_IDLE;
          done_d = 1'b1;
        end
      end
      default: tx_d = LINE_IDLE;
    endcase
  end

  // Bit-timing counters: div_cnt wraps every bit, bit_cnt indexes data bits.
  always_comb begin
    div_cnt_d = '0;
    bit_cnt_d = '0;
    if (state_q != ST_IDLE && !last_div) begin
      div_cnt_d = div_cnt_q + DivW'(1);
    end
    if (state_q == ST_DATA) begin
      bit_cnt_d = bit_cnt_q;
      if (last_div) begin
        bit_cnt_d = last_bit ? '0 : bit_cnt_q + CntW'(1);
      end
    end
  end

  // Datapath registers: counters, line level and completion pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_q      <= LINE_IDLE;
      done_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  // Even parity of the accepted word, captured alongside the load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^bus.in_data;
    end
  end
`endif

  assign bus.in_ready = (state_q == ST_IDLE);
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.tx_out   = tx_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Directed bench for serial_tx_ctrl: DIV=4 instance plus a DIV=1 instance.
module tb_serial_tx_ctrl;

`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_tx_ctrl_if #(.WIDTH(8)) ifa ();
  serial_tx_ctrl_if #(.WIDTH(8)) ifb ();

  serial_tx_ctrl #(.WIDTH(8), .DIV(4)) u_dut_a (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (ifa)
  );

  serial_tx_ctrl #(.WIDTH(8), .DIV(1)) u_dut_b (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a word for one accept edge; returns just after that edge.
  task automatic accept(input bit use_b, input logic [7:0] w);
    @(negedge clk);
    if (use_b) begin
      ifb.in_valid = 1'b1;
      ifb.in_data  = w;
    end else begin
      ifa.in_valid = 1'b1;
      ifa.in_data  = w;
    end
    @(posedge clk);
  endtask

  // Check a whole frame cycle by cycle, then the done cycle.
  task automatic run_frame(input bit use_b, input logic [7:0] w, input logic par,
                           input bit queue_next, input logic [7:0] nxt);
    int          div;
    logic [10:0] bits;
    div  = use_b ? 1 : 4;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = w[i];
    if (NBITS == 11) bits[9] = par;
    for (int n = 1; n <= NBITS * div; n++) begin
      @(negedge clk);
      chk("tx_bit",   use_b ? ifb.tx_out   : ifa.tx_out,   bits[(n-1)/div]);
      chk("busy",     use_b ? ifb.busy     : ifa.busy,     1'b1);
      chk("done_low", use_b ? ifb.done     : ifa.done,     1'b0);
      chk("ready_lo", use_b ? ifb.in_ready : ifa.in_ready, 1'b0);
      if (n == 1) begin
        ifb.in_valid = 1'b0;
        ifa.in_valid = queue_next;
        ifa.in_data  = queue_next ? nxt : 8'h00;
      end
    end
    @(negedge clk);
    chk("done_pulse", use_b ? ifb.done     : ifa.done,     1'b1);
    chk("done_ready", use_b ? ifb.in_ready : ifa.in_ready, 1'b1);
    chk("done_busy",  use_b ? ifb.busy     : ifa.busy,     1'b0);
    chk("done_tx",    use_b ? ifb.tx_out   : ifa.tx_out,   1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ifa.in_valid = 1'b0;
    ifa.in_data  = 8'h00;
    ifb.in_valid = 1'b0;
    ifb.in_data  = 8'h00;

    // Reset values while held and for 20 idle cycles after release.
    repeat (2) @(negedge clk);
    chk("rst_tx",    ifa.tx_out,   1'b1);
    chk("rst_ready", ifa.in_ready, 1'b1);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_tx",    ifa.tx_out,   1'b1);
      chk("idle_ready", ifa.in_ready, 1'b1);
      chk("idle_busy",  ifa.busy,     1'b0);
      chk("idle_done",  ifa.done,     1'b0);
    end

    // 0xA5 with 0x3C queued during the frame; 0x3C taken in the done cycle.
    accept(1'b0, 8'hA5);
    run_frame(1'b0, 8'hA5, 1'b0, 1'b1, 8'h3C);
    run_frame(1'b0, 8'h3C, 1'b0, 1'b0, 8'h00);

    // Reset during data bit 3 of 0xA5 (bit value 0): line returns high at once.
    accept(1'b0, 8'hA5);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 1) ifa.in_valid = 1'b0;
    end
    chk("bit3_tx", ifa.tx_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_tx",    ifa.tx_out,   1'b1);
    chk("arst_busy",  ifa.busy,     1'b0);
    chk("arst_ready", ifa.in_ready, 1'b1);
    chk("arst_done",  ifa.done,     1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("abandon_done", ifa.done,   1'b0);
      chk("abandon_tx",   ifa.tx_out, 1'b1);
    end
    accept(1'b0, 8'hFF);
    run_frame(1'b0, 8'hFF, 1'b0, 1'b0, 8'h00);

    // DIV=1 instance: one cycle per bit.
    accept(1'b1, 8'h01);
    run_frame(1'b1, 8'h01, 1'b1, 1'b0, 8'h00);

`ifdef SERIAL_TX_PARITY_EN
    // Parity 0 for 0xA5 (four ones), parity 1 for 0x07 (three ones).
    accept(1'b0, 8'hA5);
    run_frame(1'b0, 8'hA5, 1'b0, 1'b0, 8'h00);
    accept(1'b0, 8'h07);
    run_frame(1'b0, 8'h07, 1'b1, 1'b0, 8'h00);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
